zex_console_mbox: RTL and testbench



---
 rtl/zex_mbox_pkg.sv | 13 +
 rtl/zex_console_mbox_if.sv | 25 ++
 rtl/sync_fifo.sv | 50 +++++
 rtl/zex_console_mbox.sv | 127 ++++++++++++
 tb/tb_zex_console_mbox.sv | 184 ++++++++++++++++++
 5 files changed

// File: rtl/zex_mbox_pkg.sv
// rtl/zex_mbox_pkg.sv - shared constants and types for the console mailbox
package zex_mbox_pkg;

  localparam logic [1:0] OFS_ACK  = 2'd0;
  localparam logic [1:0] OFS_REQ  = 2'd1;
  localparam logic [1:0] OFS_DATA = 2'd2;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } drain_state_t;

endpackage

// File: rtl/zex_console_mbox_if.sv
// rtl/zex_console_mbox_if.sv - CPU mailbox bus and UART byte stream
interface zex_console_mbox_if;

  logic [15:0] addr;
  logic        mreq_n;
  logic        rd_n;
  logic        wr_n;
  logic [7:0]  din;
  logic [7:0]  dout;
  logic        dout_sel;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;

  modport slave (
    input  addr, mreq_n, rd_n, wr_n, din, tx_ready,
    output dout, dout_sel, tx_data, tx_valid
  );

  modport master (
    output addr, mreq_n, rd_n, wr_n, din, tx_ready,
    input  dout, dout_sel, tx_data, tx_valid
  );

endinterface

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO; a push while full is accepted when a pop shares the cycle
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      level
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (level == (AW+1)'(DEPTH));
  assign empty   = (level == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/zex_console_mbox.sv
// rtl/zex_console_mbox.sv - registered ACK/REQ/DATA console mailbox with TX FIFO drain
module zex_console_mbox
  import zex_mbox_pkg::*;
#(
  parameter int          FIFO_DEPTH = 16,
  parameter logic [15:0] BASE_ADDR  = 16'hFFFD
) (
  input  logic                          clk,
  input  logic                          reset,
  zex_console_mbox_if.slave             bus,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  logic [15:0]  ofs;
  logic [15:0]  addr_prev;
  logic         sel, rd_acc, wr_acc;
  logic         rd_prev, wr_prev;
  logic         rd_first, wr_first, data_wr;
  logic [7:0]   ack, req, req_last, data;
  logic         fifo_pop, fifo_full, fifo_empty;
  logic [7:0]   fifo_rdata;
  logic [7:0]   tx_data_q;
  drain_state_t state, state_d;

  // Subtracting the base keeps the window decode correct even if it straddles 0xFFFF.
  assign ofs    = bus.addr - BASE_ADDR;
  assign sel    = !bus.mreq_n && (ofs < 16'd3);
  assign rd_acc = sel && !bus.rd_n;
  assign wr_acc = sel && !bus.wr_n;

  // A strobe held over several clocks acts once: only when it was not already active at this address.
  assign rd_first = rd_acc && !(rd_prev && addr_prev == bus.addr);
  assign wr_first = wr_acc && !(wr_prev && addr_prev == bus.addr);
  assign data_wr  = wr_first && (ofs[1:0] == OFS_DATA);

  assign bus.dout_sel = rd_acc;

  always_comb begin
    bus.dout = 8'h00;
    if (sel) begin
      case (ofs[1:0])
        OFS_ACK:  bus.dout = ack;
        OFS_REQ:  bus.dout = req;
        OFS_DATA: bus.dout = data;
        default:  bus.dout = 8'h00;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ack       <= 8'h00;
      req       <= 8'h00;
      req_last  <= 8'h00;
      data      <= 8'h00;
      overflow  <= 1'b0;
      rd_prev   <= 1'b0;
      wr_prev   <= 1'b0;
      addr_prev <= 16'h0000;
    end else begin
      rd_prev   <= rd_acc;
      wr_prev   <= wr_acc;
      addr_prev <= bus.addr;
      if (rd_first && ofs[1:0] == OFS_ACK && req != req_last) begin
        ack      <= ack + 8'd1;
        req_last <= req;
      end
      if (wr_first) begin
        case (ofs[1:0])
          OFS_ACK: ack <= 8'h00;
          OFS_REQ: begin
            req_last <= req;
            req      <= bus.din;
          end
          OFS_DATA: begin
            data <= bus.din;
            if (fifo_full && !fifo_pop) overflow <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (data_wr),
    .pop   (fifo_pop),
    .wdata (bus.din),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  always_comb begin
    state_d  = state;
    fifo_pop = 1'b0;
    if (state == IDLE) begin
      if (!fifo_empty) begin
        fifo_pop = 1'b1;
        state_d  = SEND;
      end
    end else begin
      if (bus.tx_ready) state_d = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      tx_data_q <= 8'h00;
    end else begin
      state <= state_d;
      if (fifo_pop) tx_data_q <= fifo_rdata;
    end
  end

  assign bus.tx_valid = (state == SEND);
  assign bus.tx_data  = tx_data_q;

endmodule

// File: tb/tb_zex_console_mbox.sv
// tb/tb_zex_console_mbox.sv - scoreboard bench for the console mailbox
module tb_zex_console_mbox;

  localparam logic [15:0] A_ACK  = 16'hFFFD;
  localparam logic [15:0] A_REQ  = 16'hFFFE;
  localparam logic [15:0] A_DATA = 16'hFFFF;

  logic       clk = 1'b0;
  logic       reset;
  logic       overflow;
  logic [4:0] fifo_level;
  int         n_checks = 0;
  int         n_fail = 0;
  logic [7:0] exp_q[$];

  zex_console_mbox_if bus();

  zex_console_mbox #(
    .FIFO_DEPTH (16),
    .BASE_ADDR  (16'hFFFD)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus),
    .overflow   (overflow),
    .fifo_level (fifo_level)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Handshake monitor: samples mid low phase, after the bench has driven its inputs.
  always @(negedge clk) begin
    #2;
    if (!reset && bus.tx_valid && bus.tx_ready) begin
      check("tx_expected", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) check("tx_data", 32'(bus.tx_data), 32'(exp_q.pop_front()));
    end
  end

  task automatic cpu_write(input logic [15:0] a, input logic [7:0] d, input int hold);
    bus.addr = a; bus.din = d; bus.mreq_n = 1'b0; bus.wr_n = 1'b0;
    repeat (hold) @(negedge clk);
    bus.mreq_n = 1'b1; bus.wr_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic data_write(input logic [7:0] d, input bit accepted);
    if (accepted) exp_q.push_back(d);
    cpu_write(A_DATA, d, 2);
  endtask

  task automatic cpu_read(input logic [15:0] a, input int hold, output logic [7:0] d, output logic s);
    bus.addr = a; bus.mreq_n = 1'b0; bus.rd_n = 1'b0;
    repeat (hold) @(negedge clk);
    d = bus.dout; s = bus.dout_sel;
    bus.mreq_n = 1'b1; bus.rd_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    check("drain_done", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    logic [7:0] rd;
    logic       rs;
    int         vcount;
    reset = 1'b1;
    bus.addr = 16'h0000; bus.din = 8'h00;
    bus.mreq_n = 1'b1; bus.rd_n = 1'b1; bus.wr_n = 1'b1;
    bus.tx_ready = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    check("rst_dout", 32'(bus.dout), 32'h0);
    check("rst_dout_sel", 32'(bus.dout_sel), 32'h0);
    check("rst_tx_valid", 32'(bus.tx_valid), 32'h0);
    check("rst_tx_data", 32'(bus.tx_data), 32'h0);
    check("rst_overflow", 32'(overflow), 32'h0);
    check("rst_level", 32'(fifo_level), 32'h0);
    cpu_read(A_ACK, 2, rd, rs);
    check("rst_ack", 32'(rd), 32'h0);

    cpu_read(16'hFFFC, 2, rd, rs);
    check("outside_sel", 32'(rs), 32'h0);
    cpu_write(16'hFFFC, 8'h77, 2);
    check("outside_level", 32'(fifo_level), 32'h0);

    // Single byte latency: strobe first sampled in cycle N, tx_valid in N+2 for one cycle.
    bus.tx_ready = 1'b1;
    exp_q.push_back(8'h41);
    bus.addr = A_DATA; bus.din = 8'h41; bus.mreq_n = 1'b0; bus.wr_n = 1'b0;
    @(negedge clk);
    check("lat_n1_valid", 32'(bus.tx_valid), 32'h0);
    check("lat_n1_level", 32'(fifo_level), 32'h1);
    @(negedge clk);
    check("lat_n2_valid", 32'(bus.tx_valid), 32'h1);
    check("lat_n2_data", 32'(bus.tx_data), 32'h41);
    @(negedge clk);
    check("lat_n3_valid", 32'(bus.tx_valid), 32'h0);
    @(negedge clk);
    check("lat_n4_valid", 32'(bus.tx_valid), 32'h0);
    check("lat_n4_level", 32'(fifo_level), 32'h0);
    bus.mreq_n = 1'b1; bus.wr_n = 1'b1;
    @(negedge clk);
    check("lat_one_byte", 32'(exp_q.size()), 32'd0);
    cpu_read(A_DATA, 2, rd, rs);
    check("data_reg", 32'(rd), 32'h41);
    check("data_sel", 32'(rs), 32'h1);

    cpu_write(A_REQ, 8'h05, 3);
    cpu_read(A_REQ, 2, rd, rs);
    check("req_reg", 32'(rd), 32'h05);
    cpu_read(A_ACK, 3, rd, rs);
    check("ack_first", 32'(rd), 32'h01);
    cpu_read(A_ACK, 3, rd, rs);
    check("ack_no_change", 32'(rd), 32'h01);
    cpu_write(A_ACK, 8'hAA, 2);
    cpu_read(A_ACK, 2, rd, rs);
    check("ack_cleared", 32'(rd), 32'h00);

    // Walk ack up to 0xFF with a fresh REQ value before every read, then wrap it.
    for (int i = 0; i < 255; i++) begin
      cpu_write(A_REQ, 8'(i + 6), 2);
      cpu_read(A_ACK, 2, rd, rs);
    end
    check("ack_ff", 32'(rd), 32'hFF);
    cpu_write(A_REQ, 8'h05, 2);
    cpu_read(A_ACK, 2, rd, rs);
    check("ack_wrap", 32'(rd), 32'h00);

    bus.tx_ready = 1'b0;
    for (int i = 0; i <= 16; i++) data_write(8'(i), 1'b1);
    check("full_level", 32'(fifo_level), 32'd16);
    check("full_no_ovf", 32'(overflow), 32'h0);
    check("full_hold_valid", 32'(bus.tx_valid), 32'h1);
    check("full_hold_data", 32'(bus.tx_data), 32'h00);
    data_write(8'h11, 1'b0);
    check("ovf_set", 32'(overflow), 32'h1);
    check("ovf_level", 32'(fifo_level), 32'd16);
    bus.tx_ready = 1'b1;
    wait_drain(200);
    check("drain_level", 32'(fifo_level), 32'd0);
    check("ovf_sticky", 32'(overflow), 32'h1);

    bus.tx_ready = 1'b0;
    for (int i = 0; i < 6; i++) data_write(8'(8'hA0 + i), 1'b1);
    check("pre_rst_valid", 32'(bus.tx_valid), 32'h1);
    check("pre_rst_level", 32'(fifo_level), 32'd5);
    reset = 1'b1;
    @(negedge clk);
    check("mid_rst_valid", 32'(bus.tx_valid), 32'h0);
    check("mid_rst_level", 32'(fifo_level), 32'd0);
    check("mid_rst_ovf", 32'(overflow), 32'h0);
    reset = 1'b0;
    exp_q.delete();
    bus.tx_ready = 1'b1;
    vcount = 0;
    repeat (12) begin
      @(negedge clk);
      if (bus.tx_valid) vcount++;
    end
    check("post_rst_quiet", 32'(vcount), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
